uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmitter among NREQ byte-stream requesters.
//   Arbitration is round-robin at packet granularity: a grant is held until the requester's last byte, or MAX_PKT bytes.
//   The block sequences the transmitter one byte at a time: start pulse, then wait for tx_done_tick.
//   It sits between the on-chip clients and the uart_tx datapath, which is driven by the same s_tick baud generator as the receiver.
// PARAMETERS
//   NREQ     4   number of requesters, 2..16
//   DBIT     8   data bits per UART frame
//   MAX_PKT  64  max payload bytes per grant before forced release, 1..255
// PORTS
//   clk           in   1                   system clock
//   rst           in   1                   asynchronous reset, active-high
//   req_valid     in   NREQ                per-requester byte valid
//   req_data      in   NREQ*DBIT           requester i byte at [i*DBIT +: DBIT]
//   req_last      in   NREQ                qualifies req_data as the packet's final byte
//   req_ready     out  NREQ                one-hot byte accept; combinational from state, grant and req_valid
//   tx_start      out  1                   one-cycle pulse to the transmitter, registered
//   tx_din        out  DBIT                byte to the transmitter, registered, held between loads
//   tx_done_tick  in   1                   transmitter finished a frame (stop bit sent)
//   grant_valid   out  1                   a packet grant is active
//   grant_id      out  $clog2(NREQ)        index of the granted requester
// BEHAVIOUR
//   Reset values:
//   - All outputs are 0.
//   - The round-robin pointer (last_id) resets to NREQ-1, so requester 0 wins first.
//   - The byte counter resets to 0.
//   State machine:
//   - IDLE: when |req_valid, grant = first set req_valid searching from last_id+1 (mod NREQ).
//     Next cycle: grant_id = grant, grant_valid = 1, byte_cnt = 0, state goes to TAG or SEND.
//   - SEND: req_ready[grant] = req_valid[grant].
//     On accept, next cycle: tx_din = data, tx_start = 1, last_seen = req_last, byte_cnt += 1, state goes to WAIT.
//     If req_valid[grant] is 0, stay in SEND indefinitely, keeping the grant.
//   - WAIT: tx_start drops after one cycle. On tx_done_tick:
//     - last_seen or byte_cnt == MAX_PKT: go to IDLE, last_id = grant, grant_valid = 0.
//     - otherwise: go to SEND.
//   Timing and boundaries:
//   - Accept-to-tx_start latency is 1 cycle.
//   - The minimum gap between frames is 2 cycles after tx_done_tick.
//   - tx_done_tick outside WAIT is ignored.
//   - req_ready is never asserted outside SEND, and never to a non-granted requester.
//   - A single requester that is continuously valid is re-granted after IDLE; there is no starvation, because the pointer advances.
//   - A forced release at MAX_PKT does not consume req_last. The remainder of that packet competes as a new packet.
//   - Reset mid-frame aborts the packet immediately. The transmitter may still finish the frame in flight; its done tick is ignored.
// CONFIGURATION
//   UART_TX_ARB_TAG_EN defined:
//   - TAG state is inserted after IDLE. It sends header byte (8'hA0 | grant_id), zero-extended or truncated to DBIT.
//   - Sequence: tx_start, wait tx_done_tick, then go to SEND.
//   - The tag is not counted in byte_cnt, and req_ready stays 0 during TAG.
//   UART_TX_ARB_TAG_EN undefined: IDLE goes straight to SEND, and the TAG state is not elaborated.
// STRUCTURE
//   uart_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_TAG, ARB_SEND, ARB_WAIT} arb_state_t
//   - localparam TAG_BASE = 8'hA0
//   Sub-module rr_arbiter (NREQ):
//   - combinational; inputs req vector and last_id; outputs grant index and any-valid flag
//   - reusable by the planned rx-side demux
//   Top holds the FSM, the counters, and the registered tx_start/tx_din.
// TESTING
//   1. Only req 2 valid, 3-byte packet 11,22,33 (last on 33) -> three tx_start pulses, tx_din = 11/22/33 in order.
//      grant_id = 2 throughout, then grant_valid drops after the third done tick.
//   2. Reqs 0,1,3 valid together, 1-byte packets -> grant order 0,1,3, then 0 again on a repeat. The pointer wraps from 3 back to 0.
//   3. Req 1 sends 70 bytes with no last, MAX_PKT = 64 -> release after byte 64.
//      Req 0 (waiting) is granted next, and req 1 resumes afterwards with 6 bytes.
//   4. Req 0 drops valid mid-packet for 50 cycles -> no tx_start, grant held.
//      Stray tx_done_tick in SEND is ignored, and the packet resumes intact.
//   5. rst asserted in WAIT -> all outputs 0 in the same cycle. The next grant goes to req 0 regardless of the prior pointer.
//   6. With UART_TX_ARB_TAG_EN, req 3 sends 1 byte 5A -> tx_din A3 then 5A. req_ready[3] stays low until the A3 done tick.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and constants for the UART TX arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_TAG  = 2'd1,
        ARB_SEND = 2'd2,
        ARB_WAIT = 2'd3
    } arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'hA0;

    // Header byte announcing which requester owns the following payload.
    function automatic logic [7:0] tag_byte(input logic [7:0] i_id);
        return TAG_BASE | i_id;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_if
//  Brief    : Requester byte streams plus transmitter handshake bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
) ();
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*DBIT-1:0]    req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic                    tx_start;
    logic [DBIT-1:0]         tx_din;
    logic                    tx_done_tick;
    logic                    grant_valid;
    logic [$clog2(NREQ)-1:0] grant_id;

    // Clients and transmitter side
    modport master (
        output req_valid, req_data, req_last, tx_done_tick,
        input  req_ready, tx_start, tx_din, grant_valid, grant_id
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, tx_done_tick,
        output req_ready, tx_start, tx_din, grant_valid, grant_id
    );
endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick: first set request after last_id.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  wire logic [NREQ-1:0]         i_req,
    input  wire logic [$clog2(NREQ)-1:0] i_last_id,
    output logic      [$clog2(NREQ)-1:0] o_grant,
    output logic                         o_any
);
    localparam int c_IDW = $clog2(NREQ);

    // Scan from farthest to nearest so the nearest set request overwrites last.
    always_comb begin
        int idx;
        idx     = 0;
        o_grant = '0;
        o_any   = |i_req;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(i_last_id) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (i_req[c_IDW'(idx)]) begin
                o_grant = c_IDW'(idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Packet-granular round-robin sharing of one UART transmitter.
//             Optional header byte per grant: define UART_TX_ARB_TAG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int MAX_PKT = 64
) (
    input wire logic         clk,
    input wire logic         rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int c_IDW = $clog2(NREQ);

    arb_state_t       r_state;
    logic [c_IDW-1:0] r_grant_id;
    logic [c_IDW-1:0] r_last_id;
    logic             r_grant_valid;
    logic             r_last_seen;
    logic             r_tx_start;
    logic [DBIT-1:0]  r_tx_din;
    logic [7:0]       r_byte_cnt;

    logic [c_IDW-1:0] w_rr_grant;
    logic             w_rr_any;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [DBIT-1:0]  w_sel_data;
    logic [NREQ-1:0]  w_ready;
    logic             w_pkt_done;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .i_req     (bus.req_valid),
        .i_last_id (r_last_id),
        .o_grant   (w_rr_grant),
        .o_any     (w_rr_any)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == c_IDW'(i)) begin
                w_sel_valid = bus.req_valid[i];
                w_sel_last  = bus.req_last[i];
                w_sel_data  = bus.req_data[i*DBIT +: DBIT];
            end
        end
    end

    // Only the granted requester ever sees ready, and only while in SEND.
    always_comb begin
        w_ready = '0;
        if (r_state == ARB_SEND) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_grant_id == c_IDW'(i)) begin
                    w_ready[i] = bus.req_valid[i];
                end
            end
        end
    end

    // Forced release at MAX_PKT leaves the rest of the packet queued upstream.
    assign w_pkt_done = r_last_seen || (r_byte_cnt == 8'(MAX_PKT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_grant_id    <= '0;
            r_last_id     <= c_IDW'(NREQ - 1);
            r_grant_valid <= 1'b0;
            r_last_seen   <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_din      <= '0;
            r_byte_cnt    <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_rr_any) begin
                        r_grant_id    <= w_rr_grant;
                        r_grant_valid <= 1'b1;
                        r_byte_cnt    <= '0;
`ifdef UART_TX_ARB_TAG_EN
                        r_tx_start    <= 1'b1;
                        r_tx_din      <= DBIT'(tag_byte(8'(w_rr_grant)));
                        r_state       <= ARB_TAG;
`else
                        r_state       <= ARB_SEND;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                ARB_TAG: begin
                    if (bus.tx_done_tick) begin
                        r_state <= ARB_SEND;
                    end
                end
`endif
                ARB_SEND: begin
                    if (w_sel_valid) begin
                        r_tx_din    <= w_sel_data;
                        r_tx_start  <= 1'b1;
                        r_last_seen <= w_sel_last;
                        r_byte_cnt  <= r_byte_cnt + 8'd1;
                        r_state     <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus.tx_done_tick) begin
                        if (w_pkt_done) begin
                            r_last_id     <= r_grant_id;
                            r_grant_valid <= 1'b0;
                            r_state       <= ARB_IDLE;
                        end else begin
                            r_state <= ARB_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.tx_start    = r_tx_start;
    assign bus.tx_din      = r_tx_din;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;

    a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(w_ready));
    a_ready_in_send : assert property (@(posedge clk) disable iff (rst)
        (w_ready != '0) |-> (r_state == ARB_SEND && r_grant_valid));
    a_start_pulse : assert property (@(posedge clk) disable iff (rst)
        r_tx_start |=> !r_tx_start);

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Directed self-checking bench with requester queues and a
//             behavioural transmitter that answers each start with a done tick.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int DBIT    = 8;
    localparam int MAX_PKT = 64;
    localparam int FRAME   = 6;

    logic clk;
    logic rst;
    logic mdone;
    logic stray;
    logic busy;
    int   cyc;
    int   acc_cyc;
    int   start_cyc;
    int   n_checks;
    int   n_errors;

    logic [8:0]  pmem [NREQ][256];
    int          wp   [NREQ];
    int          rp   [NREQ];
    logic [11:0] log_q[$];
    logic [11:0] exp_q[$];

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DBIT    (DBIT),
        .MAX_PKT (MAX_PKT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.tx_done_tick = mdone | stray;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester side: pop on accepted byte, present next queued byte.
    initial begin
        logic [NREQ-1:0] acc;
        for (int i = 0; i < NREQ; i++) rp[i] = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_ready;
            if (acc != '0) acc_cyc = cyc;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) rp[i]++;
                bus.req_valid[i]        = (rp[i] != wp[i]);
                bus.req_last[i]         = pmem[i][rp[i] % 256][8];
                bus.req_data[i*DBIT +: DBIT] = pmem[i][rp[i] % 256][7:0];
            end
        end
    end

    // Transmitter model: logs {grant_id, byte} on each start, done FRAME cycles later.
    initial begin
        mdone = 1'b0;
        busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                log_q.push_back({4'(bus.grant_id), bus.tx_din});
                start_cyc = cyc;
                busy = 1'b1;
                repeat (FRAME - 1) @(negedge clk);
                mdone = 1'b1;
                @(negedge clk);
                mdone = 1'b0;
                busy  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic load(input int id, input logic [7:0] b, input logic last);
        pmem[id][wp[id] % 256] = {last, b};
        wp[id]++;
    endtask

    task automatic push_tag(input int id);
`ifdef UART_TX_ARB_TAG_EN
        exp_q.push_back({4'(id), 8'hA0 | 8'(id)});
`endif
    endtask

    task automatic push_byte(input int id, input logic [7:0] b);
        exp_q.push_back({4'(id), b});
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_byte"}, log_q[i], exp_q[i]);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            tick();
            n++;
            done = !bus.grant_valid && !busy && !bus.tx_start;
            for (int i = 0; i < NREQ; i++) if (rp[i] != wp[i]) done = 1'b0;
        end
        if (!done) chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_log(input string tag, input int n);
        int k;
        k = 0;
        while (log_q.size() < n && k < 500) begin
            tick();
            k++;
        end
        if (log_q.size() < n) chk({tag, "_log_timeout"}, log_q.size(), n);
    endtask

    task automatic wait_not_busy(input string tag);
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        if (busy) chk({tag, "_busy_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int ntag;
    int n0;
    int bad;

    initial begin
        n_checks = 0;
        n_errors = 0;
        stray    = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < NREQ; i++) wp[i] = 0;
`ifdef UART_TX_ARB_TAG_EN
        ntag = 1;
`else
        ntag = 0;
`endif
        repeat (3) tick();
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_din", bus.tx_din, 0);
        chk("rst_grant_valid", bus.grant_valid, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rst = 1'b0;

        // Test 1: single requester, three-byte packet
        load(2, 8'h11, 1'b0);
        load(2, 8'h22, 1'b0);
        load(2, 8'h33, 1'b1);
        push_tag(2);
        push_byte(2, 8'h11);
        push_byte(2, 8'h22);
        push_byte(2, 8'h33);
        wait_idle("t1");
        chk("t1_latency", start_cyc - acc_cyc, 1);
        chk("t1_grant_valid_end", bus.grant_valid, 0);
        compare_logs("t1");

        // Test 2: round robin 0,1,3 then wrap to 0
        do_reset();
        load(0, 8'h30, 1'b1);
        load(1, 8'h31, 1'b1);
        load(3, 8'h33, 1'b1);
        push_tag(0); push_byte(0, 8'h30);
        push_tag(1); push_byte(1, 8'h31);
        push_tag(3); push_byte(3, 8'h33);
        wait_idle("t2a");
        load(0, 8'h40, 1'b1);
        load(1, 8'h41, 1'b1);
        push_tag(0); push_byte(0, 8'h40);
        push_tag(1); push_byte(1, 8'h41);
        wait_idle("t2b");
        compare_logs("t2");

        // Test 3: 70-byte packet forced off at MAX_PKT, waiting req 0 slips in
        for (int i = 0; i < 70; i++) load(1, 8'(8'h80 + i), (i == 69));
        n0 = 0;
        while (!bus.grant_valid && n0 < 50) begin
            tick();
            n0++;
        end
        chk("t3_grant_id", bus.grant_id, 1);
        load(0, 8'h5E, 1'b1);
        push_tag(1);
        for (int i = 0; i < MAX_PKT; i++) push_byte(1, 8'(8'h80 + i));
        push_tag(0);
        push_byte(0, 8'h5E);
        push_tag(1);
        for (int i = MAX_PKT; i < 70; i++) push_byte(1, 8'(8'h80 + i));
        wait_idle("t3");
        compare_logs("t3");

        // Test 4: requester stalls mid-packet, stray done tick in SEND
        load(0, 8'hA1, 1'b0);
        wait_log("t4", ntag + 1);
        wait_not_busy("t4");
        n0 = log_q.size();
        for (int c = 0; c < 50; c++) begin
            tick();
            if (c == 10) stray = 1'b1;
            if (c == 11) stray = 1'b0;
        end
        chk("t4_no_start", log_q.size(), n0);
        chk("t4_grant_valid", bus.grant_valid, 1);
        chk("t4_grant_id", bus.grant_id, 0);
        chk("t4_req_ready", bus.req_ready, 0);
        load(0, 8'hB2, 1'b0);
        load(0, 8'hC3, 1'b1);
        push_tag(0);
        push_byte(0, 8'hA1);
        push_byte(0, 8'hB2);
        push_byte(0, 8'hC3);
        wait_idle("t4");
        compare_logs("t4");

        // Test 5: reset while waiting on a frame, pointer returns to req 0
        load(2, 8'h77, 1'b0);
        load(2, 8'h78, 1'b1);
        push_tag(2);
        push_byte(2, 8'h77);
        wait_log("t5", ntag + 1);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_tx_start", bus.tx_start, 0);
        chk("t5_tx_din", bus.tx_din, 0);
        chk("t5_grant_valid", bus.grant_valid, 0);
        chk("t5_grant_id", bus.grant_id, 0);
        chk("t5_req_ready", bus.req_ready, 0);
        wp[2] = rp[2];
        tick();
        rst = 1'b0;
        wait_not_busy("t5");
        tick();
        compare_logs("t5a");
        load(3, 8'h63, 1'b1);
        load(0, 8'h60, 1'b1);
        push_tag(0); push_byte(0, 8'h60);
        push_tag(3); push_byte(3, 8'h63);
        wait_idle("t5b");
        compare_logs("t5b");

`ifdef UART_TX_ARB_TAG_EN
        // Test 6: header byte precedes payload; no ready during the header
        load(3, 8'h5A, 1'b1);
        push_tag(3);
        push_byte(3, 8'h5A);
        wait_log("t6", 1);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (!busy) break;
            if (bus.req_ready != '0) bad++;
        end
        chk("t6_ready_during_tag", bad, 0);
        wait_idle("t6");
        compare_logs("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
